// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one fixed-latency CORDIC between two
// requesters, with tag tracking, credit control and per-requester FIFOs.
module cordic_arbiter #(
  parameter int W     = 32,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  output logic [W-1:0] cordic_dataa,
  input  logic [W-1:0] cordic_result,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] rsp_rdy;

  logic           ptr_q, ptr_d;
  logic [LAT-1:0] tv_q, tv_d;
  logic [LAT-1:0] tid_q, tid_d;
  logic [W-1:0]   dataa_q, dataa_d;

  logic [1:0][CW-1:0] cred_q, cred_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0][AW-1:0] wp_q, wp_d;
  logic [1:0][AW-1:0] rp_q, rp_d;

  logic [1:0][DEPTH-1:0][W-1:0] mem_q, mem_d;

  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  always_comb begin
    elig[0] = req0_valid && (cred_q[0] < CW'(DEPTH));
    elig[1] = req1_valid && (cred_q[1] < CW'(DEPTH));
    grant   = 2'b00;
    // On a tie the requester that did not win last time goes first
    unique case (1'b1)
      (elig == 2'b11): grant = ptr_q ? 2'b01 : 2'b10;
      (elig == 2'b01): grant = 2'b01;
      (elig == 2'b10): grant = 2'b10;
      default:         grant = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    dataa_d = dataa_q;
    if (grant[1]) begin
      ptr_d   = 1'b1;
      dataa_d = req1_data;
    end else if (grant[0]) begin
      ptr_d   = 1'b0;
      dataa_d = req0_data;
    end
    tv_d[0]  = |grant;
    tid_d[0] = grant[1];
    for (int i = 1; i < LAT; i++) begin
      tv_d[i]  = tv_q[i-1];
      tid_d[i] = tid_q[i-1];
    end
  end

  always_comb begin
    push[0] = tv_q[LAT-1] && !tid_q[LAT-1];
    push[1] = tv_q[LAT-1] && tid_q[LAT-1];
    mem_d   = mem_q;
    for (int r = 0; r < 2; r++) begin
      pop[r]  = (cnt_q[r] != '0) && rsp_rdy[r];
      cred_d[r] = cred_q[r] + CW'(grant[r])
                - CW'(pop[r]);
      cnt_d[r] = cnt_q[r] + CW'(push[r])
               - CW'(pop[r]);
      wp_d[r] = wp_q[r] + AW'(push[r]);
      rp_d[r] = rp_q[r] + AW'(pop[r]);
      if (push[r]) begin
        mem_d[r][wp_q[r]] = cordic_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= 1'b0;
      tv_q    <= '0;
      tid_q   <= '0;
      dataa_q <= '0;
      cred_q  <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tv_q    <= tv_d;
      tid_q   <= tid_d;
      dataa_q <= dataa_d;
      cred_q  <= cred_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign cordic_dataa = dataa_q;
  assign rsp0_valid   = cnt_q[0] != '0;
  assign rsp1_valid   = cnt_q[1] != '0;
  assign rsp0_data    = mem_q[0][rp_q[0]];
  assign rsp1_data    = mem_q[1][rp_q[1]];
  assign busy = (|tv_q) || rsp0_valid || rsp1_valid;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push[0] && cnt_q[0] == CW'(DEPTH)))
        else $error("fifo0 push while full");
      assert (!(push[1] && cnt_q[1] == CW'(DEPTH)))
        else $error("fifo1 push while full");
    end
  end
`endif

endmodule
